// File: rtl/ras_pkg.sv
// Shared widths and checkpoint record for the return-address-stack controller.
package ras_pkg;
  localparam int XLEN  = 32;
  localparam int DEPTH = 16;
  localparam int NCKPT = 4;
  localparam int PW    = $clog2(DEPTH);
  localparam int CKW   = $clog2(NCKPT);

  localparam logic [PW:0]  DEPTH_CNT = (PW+1)'(DEPTH);
  localparam logic [CKW:0] NCKPT_CNT = (CKW+1)'(NCKPT);

  typedef struct packed {
    logic [PW-1:0]   tos;
    logic [PW:0]     count;
    logic [XLEN-1:0] top;
  } ras_ckpt_t;
endpackage

// File: rtl/ras_ckpt_queue.sv
// Circular queue of RAS snapshots, one per in-flight branch, oldest at head.
module ras_ckpt_queue
  import ras_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           alloc,
  input  ras_ckpt_t      alloc_data,
  input  logic           free,
  input  logic           truncate,
  input  logic [CKW-1:0] truncate_id,
  input  logic [CKW-1:0] rd_id,
  output ras_ckpt_t      rd_data,
  output logic [CKW-1:0] tail,
  output logic           full
);
  logic [CKW-1:0] head_r, tail_r, head_nxt_s, tail_nxt_s;
  logic [CKW:0]   used_r, used_nxt_s, trunc_used_s;
  logic           free_ok_s, alloc_ok_s, full_s;
  ras_ckpt_t      slot_r [NCKPT];

  // Pointer/occupancy update; a free in the same cycle vacates room for an alloc while full.
  always_comb begin
    full_s       = (used_r == NCKPT_CNT);
    free_ok_s    = free && (used_r != {(CKW+1){1'b0}});
    alloc_ok_s   = alloc && !truncate && (!full_s || free_ok_s);
    head_nxt_s   = head_r + CKW'(free_ok_s);
    trunc_used_s = {1'b0, truncate_id - head_r} + (CKW+1)'(1);
    if (truncate) begin
      tail_nxt_s = truncate_id + CKW'(1);
      used_nxt_s = trunc_used_s - (CKW+1)'(free_ok_s);
    end else begin
      tail_nxt_s = tail_r + CKW'(alloc_ok_s);
      used_nxt_s = used_r + (CKW+1)'(alloc_ok_s) - (CKW+1)'(free_ok_s);
    end
  end

  // Queue pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r <= {CKW{1'b0}};
      tail_r <= {CKW{1'b0}};
      used_r <= {(CKW+1){1'b0}};
    end else begin
      head_r <= head_nxt_s;
      tail_r <= tail_nxt_s;
      used_r <= used_nxt_s;
    end
  end

  // Snapshot storage, intentionally not reset.
  always_ff @(posedge clk) begin
    if (alloc_ok_s) slot_r[tail_r] <= alloc_data;
  end

  assign rd_data = slot_r[rd_id];
  assign tail    = tail_r;
  assign full    = full_s;
endmodule

// File: rtl/ras_ctrl.sv
// Speculative return-address stack with per-branch checkpoints and flush repair.
module ras_ctrl
  import ras_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            call_valid,
  input  logic [XLEN-1:0] call_addr,
  input  logic            ret_valid,
  output logic            pred_valid,
  output logic [XLEN-1:0] pred_addr,
  input  logic            ckpt_alloc,
  output logic [CKW-1:0]  ckpt_id,
  output logic            ckpt_full,
  input  logic            ckpt_free,
  input  logic            flush_valid,
  input  logic [CKW-1:0]  flush_id,
  output logic            ras_empty
);
  logic [PW-1:0]   tos_r, tos_nxt_s, tos_dec_s, wr_idx_s;
  logic [PW:0]     count_r, count_nxt_s;
  logic [XLEN-1:0] ras_r [DEPTH];
  logic [XLEN-1:0] top_s, wr_data_s;
  logic            nonempty_s, wr_en_s;
  ras_ckpt_t       snap_s, restore_s;

  assign tos_dec_s  = tos_r - PW'(1);
  assign top_s      = ras_r[tos_dec_s];
  assign nonempty_s = (count_r != {(PW+1){1'b0}});
  assign ras_empty  = !nonempty_s;
  assign snap_s     = '{tos: tos_r, count: count_r, top: top_s};

  // Zero-latency prediction from the current top; suppressed by a flush.
  always_comb begin
    if (ret_valid && nonempty_s && !flush_valid) begin
      pred_valid = 1'b1;
      pred_addr  = top_s;
    end else begin
      pred_valid = 1'b0;
      pred_addr  = {XLEN{1'b0}};
    end
  end

  // Flush restore beats call/ret; call+ret on a non-empty stack replaces the top in place.
  always_comb begin
    tos_nxt_s   = tos_r;
    count_nxt_s = count_r;
    wr_en_s     = 1'b0;
    wr_idx_s    = tos_r;
    wr_data_s   = call_addr;
    if (flush_valid) begin
      tos_nxt_s   = restore_s.tos;
      count_nxt_s = restore_s.count;
      wr_en_s     = 1'b1;
      wr_idx_s    = restore_s.tos - PW'(1);
      wr_data_s   = restore_s.top;
    end else if (call_valid && ret_valid && nonempty_s) begin
      wr_en_s  = 1'b1;
      wr_idx_s = tos_dec_s;
    end else if (call_valid) begin
      wr_en_s     = 1'b1;
      tos_nxt_s   = tos_r + PW'(1);
      count_nxt_s = (count_r == DEPTH_CNT) ? count_r : count_r + (PW+1)'(1);
    end else if (ret_valid && nonempty_s) begin
      tos_nxt_s   = tos_dec_s;
      count_nxt_s = count_r - (PW+1)'(1);
    end else begin
      tos_nxt_s   = tos_r;
      count_nxt_s = count_r;
    end
  end

  // Stack pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tos_r   <= {PW{1'b0}};
      count_r <= {(PW+1){1'b0}};
    end else begin
      tos_r   <= tos_nxt_s;
      count_r <= count_nxt_s;
    end
  end

  // Return-address storage, intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) ras_r[wr_idx_s] <= wr_data_s;
  end

  ras_ckpt_queue u_ckpt (
    .clk         (clk),
    .rst_n       (rst_n),
    .alloc       (ckpt_alloc),
    .alloc_data  (snap_s),
    .free        (ckpt_free),
    .truncate    (flush_valid),
    .truncate_id (flush_id),
    .rd_id       (flush_id),
    .rd_data     (restore_s),
    .tail        (ckpt_id),
    .full        (ckpt_full)
  );
endmodule

// File: tb/tb_ras_ctrl.sv
// Directed self-checking bench for ras_ctrl.
module tb_ras_ctrl;
  logic        clk, rst_n;
  logic        call_valid, ret_valid, ckpt_alloc, ckpt_free, flush_valid;
  logic [31:0] call_addr, pred_addr;
  logic        pred_valid, ckpt_full, ras_empty;
  logic [1:0]  ckpt_id, flush_id;
  int          n_chk = 0, n_pass = 0, n_fail = 0;

  ras_ctrl dut (
    .clk(clk), .rst_n(rst_n), .call_valid(call_valid), .call_addr(call_addr),
    .ret_valid(ret_valid), .pred_valid(pred_valid), .pred_addr(pred_addr),
    .ckpt_alloc(ckpt_alloc), .ckpt_id(ckpt_id), .ckpt_full(ckpt_full),
    .ckpt_free(ckpt_free), .flush_valid(flush_valid), .flush_id(flush_id),
    .ras_empty(ras_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs;
    call_valid = 1'b0; call_addr = 32'h0; ret_valid = 1'b0;
    ckpt_alloc = 1'b0; ckpt_free = 1'b0; flush_valid = 1'b0; flush_id = 2'd0;
  endtask

  // Apply inputs after a falling edge, leaving time for combinational outputs to settle.
  task automatic drive(input logic c, input logic [31:0] a, input logic r,
                       input logic al, input logic fr, input logic fl, input logic [1:0] fid);
    @(negedge clk);
    call_valid = c; call_addr = a; ret_valid = r;
    ckpt_alloc = al; ckpt_free = fr; flush_valid = fl; flush_id = fid;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic do_reset;
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic push(input logic [31:0] a);
    drive(1'b1, a, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    tick();
  endtask

  task automatic pop_expect(input string tag, input logic [31:0] a);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    chk({tag, "_pv"}, {31'h0, pred_valid}, 32'd1);
    chk({tag, "_pa"}, pred_addr, a);
    tick();
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    #1;
    chk("rst_pv", {31'h0, pred_valid}, 32'd0);
    chk("rst_pa", pred_addr, 32'h0);
    chk("rst_empty", {31'h0, ras_empty}, 32'd1);
    chk("rst_full", {31'h0, ckpt_full}, 32'd0);
    chk("rst_id", {30'h0, ckpt_id}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: pop on empty stack
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    chk("t1_pv", {31'h0, pred_valid}, 32'd0);
    chk("t1_pa", pred_addr, 32'h0);
    tick();
    chk("t1_empty", {31'h0, ras_empty}, 32'd1);

    // 2: basic LIFO
    push(32'h100); push(32'h200); push(32'h300);
    chk("t2_nonempty", {31'h0, ras_empty}, 32'd0);
    pop_expect("t2_p0", 32'h300);
    pop_expect("t2_p1", 32'h200);
    pop_expect("t2_p2", 32'h100);
    chk("t2_empty", {31'h0, ras_empty}, 32'd1);

    // 3: overflow overwrites oldest entry
    do_reset();
    for (int i = 0; i <= 16; i++) push(32'hA000 + 32'(i));
    for (int i = 16; i >= 1; i--) pop_expect("t3_pop", 32'hA000 + 32'(i));
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    chk("t3_pv17", {31'h0, pred_valid}, 32'd0);
    tick();
    chk("t3_empty", {31'h0, ras_empty}, 32'd1);

    // 4: checkpoint restore repairs an overwritten top
    do_reset();
    push(32'h10); push(32'h20);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    chk("t4_id", {30'h0, ckpt_id}, 32'd0);
    tick();
    pop_expect("t4_spec", 32'h20);
    push(32'h99);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0);
    chk("t4_flush_pv", {31'h0, pred_valid}, 32'd0);
    tick();
    chk("t4_id_after", {30'h0, ckpt_id}, 32'd1);
    pop_expect("t4_r0", 32'h20);
    pop_expect("t4_r1", 32'h10);
    chk("t4_empty", {31'h0, ras_empty}, 32'd1);

    // 5: checkpoint occupancy
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
      chk("t5_id", {30'h0, ckpt_id}, 32'(i));
      chk("t5_notfull", {31'h0, ckpt_full}, 32'd0);
      tick();
    end
    chk("t5_full", {31'h0, ckpt_full}, 32'd1);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0);
    chk("t5_af_id", {30'h0, ckpt_id}, 32'd0);
    tick();
    chk("t5_af_full", {31'h0, ckpt_full}, 32'd1);
    chk("t5_af_id2", {30'h0, ckpt_id}, 32'd1);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
    tick();
    chk("t5_free_full", {31'h0, ckpt_full}, 32'd0);
    chk("t5_free_id", {30'h0, ckpt_id}, 32'd1);

    // 6: call+ret replaces the top, then async reset mid-sequence
    do_reset();
    push(32'h40);
    drive(1'b1, 32'h77, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    chk("t6_cr_pv", {31'h0, pred_valid}, 32'd1);
    chk("t6_cr_pa", pred_addr, 32'h40);
    tick();
    chk("t6_cr_nonempty", {31'h0, ras_empty}, 32'd0);
    pop_expect("t6_top", 32'h77);
    chk("t6_cr_count", {31'h0, ras_empty}, 32'd1);
    push(32'h55); push(32'h66);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    tick();
    chk("t6_pre_id", {30'h0, ckpt_id}, 32'd1);
    @(posedge clk);
    #2;
    ret_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_pv", {31'h0, pred_valid}, 32'd0);
    chk("t6_rst_pa", pred_addr, 32'h0);
    chk("t6_rst_empty", {31'h0, ras_empty}, 32'd1);
    chk("t6_rst_id", {30'h0, ckpt_id}, 32'd0);
    chk("t6_rst_full", {31'h0, ckpt_full}, 32'd0);
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    tick();
    chk("t6_post_empty", {31'h0, ras_empty}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
